// File: rtl/player_hand.sv
// Card hand store: collects cards from the deck on draw requests and removes a chosen slot on play,
// keeping the valid slots packed from slot 0 upward.
module player_hand #(
    parameter int unsigned MAX_CARDS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_req_draw,
    input  logic       i_play,
    input  logic [4:0] i_play_idx,
    input  logic [4:0] i_rd_idx,
    input  logic       i_deck_done,
    input  logic       i_deck_drawn,
    input  logic [5:0] i_deck_card,
    output logic [2:0] o_draw,
    output logic       o_insert,
    output logic [5:0] o_play_card,
    output logic [5:0] o_rd_card,
    output logic [4:0] o_count,
    output logic       o_busy,
    output logic       o_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_DECK, S_DRAW, S_PLAY} state_e;

    localparam logic [5:0] MaxCards6 = 6'(MAX_CARDS);

    state_e     state_q, state_d;
    logic [5:0] hand_q [MAX_CARDS];
    logic [5:0] hand_d [MAX_CARDS];
    logic [4:0] count_q, count_d;
    logic [2:0] remaining_q, remaining_d;
    logic [2:0] code_q, code_d;
    logic [4:0] play_idx_q, play_idx_d;
    logic [5:0] play_card_q, play_card_d;
    logic       err_q, err_d;

    logic       draw_onehot;
    logic [2:0] draw_n;
    logic       draw_fits;
    logic [5:0] play_sel;

    always_comb begin
        draw_n = 3'd0;
        case (i_req_draw)
            3'b001:  draw_n = 3'd1;
            3'b010:  draw_n = 3'd2;
            3'b100:  draw_n = 3'd4;
            default: draw_n = 3'd0;
        endcase
    end

    assign draw_onehot = (draw_n != 3'd0);
    assign draw_fits   = ({1'b0, count_q} + {3'b000, draw_n}) <= MaxCards6;

    always_comb begin
        play_sel = '0;
        for (int i = 0; i < int'(MAX_CARDS); i++) begin
            if (5'(i) == i_play_idx) play_sel = hand_q[i];
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        hand_d      = hand_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        code_d      = code_q;
        play_idx_d  = play_idx_q;
        play_card_d = play_card_q;
        err_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A nonzero draw request wins; any simultaneous play is silently dropped.
                if (i_req_draw != 3'b000) begin
                    if (draw_onehot && draw_fits) begin
                        code_d      = i_req_draw;
                        remaining_d = draw_n;
                        state_d     = i_deck_done ? S_DRAW : S_WAIT_DECK;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (i_play) begin
                    if (i_play_idx < count_q) begin
                        play_card_d = play_sel;
                        play_idx_d  = i_play_idx;
                        state_d     = S_PLAY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT_DECK: begin
                if (i_deck_done) state_d = S_DRAW;
            end
            S_DRAW: begin
                if (i_deck_drawn) begin
                    for (int i = 0; i < int'(MAX_CARDS); i++) begin
                        if (5'(i) == count_q) hand_d[i] = i_deck_card;
                    end
                    count_d     = count_q + 5'd1;
                    remaining_d = remaining_q - 3'd1;
                    if (remaining_q == 3'd1) state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                for (int i = 0; i < int'(MAX_CARDS) - 1; i++) begin
                    if (5'(i) >= play_idx_q && 5'(i) < count_q - 5'd1) hand_d[i] = hand_q[i+1];
                end
                // Clear the vacated top slot so stale cards never linger above count.
                for (int i = 0; i < int'(MAX_CARDS); i++) begin
                    if (5'(i) == count_q - 5'd1) hand_d[i] = '0;
                end
                count_d = count_q - 5'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hand_q      <= '{default: '0};
            count_q     <= '0;
            remaining_q <= '0;
            code_q      <= '0;
            play_idx_q  <= '0;
            play_card_q <= '0;
            err_q       <= 1'b0;
        end else begin
            hand_q      <= hand_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            code_q      <= code_d;
            play_idx_q  <= play_idx_d;
            play_card_q <= play_card_d;
            err_q       <= err_d;
        end
    end

    // Outputs
    always_comb begin
        o_draw      = (state_q == S_DRAW) ? code_q : 3'b000;
        o_insert    = (state_q == S_PLAY);
        o_busy      = (state_q != S_IDLE);
        o_count     = count_q;
        o_err       = err_q;
        o_play_card = play_card_q;
        o_rd_card   = '0;
        for (int i = 0; i < int'(MAX_CARDS); i++) begin
            if (5'(i) == i_rd_idx && i_rd_idx < count_q) o_rd_card = hand_q[i];
        end
    end

endmodule

// File: tb/tb_player_hand.sv
// Directed bench for player_hand: draw, play, reject, priority and async-reset cases.
module tb_player_hand;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [2:0] i_req_draw;
    logic       i_play;
    logic [4:0] i_play_idx;
    logic [4:0] i_rd_idx;
    logic       i_deck_done;
    logic       i_deck_drawn;
    logic [5:0] i_deck_card;
    logic [2:0] o_draw;
    logic       o_insert;
    logic [5:0] o_play_card;
    logic [5:0] o_rd_card;
    logic [4:0] o_count;
    logic       o_busy;
    logic       o_err;

    int n_checks = 0;
    int n_pass   = 0;

    player_hand #(.MAX_CARDS(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_draw  (i_req_draw),
        .i_play      (i_play),
        .i_play_idx  (i_play_idx),
        .i_rd_idx    (i_rd_idx),
        .i_deck_done (i_deck_done),
        .i_deck_drawn(i_deck_drawn),
        .i_deck_card (i_deck_card),
        .o_draw      (o_draw),
        .o_insert    (o_insert),
        .o_play_card (o_play_card),
        .o_rd_card   (o_rd_card),
        .o_count     (o_count),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input int idx, input logic [31:0] exp);
        i_rd_idx = 5'(idx);
        #1;
        check(tag, 32'(o_rd_card), exp);
    endtask

    task automatic draw_cards(input logic [2:0] code, input int n, input logic [5:0] base,
                              input int exp_count);
        i_req_draw = code;
        step();
        i_req_draw = 3'b000;
        for (int k = 0; k < n; k++) begin
            i_deck_drawn = 1'b1;
            i_deck_card  = base + 6'(k);
            step();
        end
        i_deck_drawn = 1'b0;
        check("draw_cards_count", 32'(o_count), 32'(exp_count));
        check("draw_cards_idle", 32'(o_busy), 0);
    endtask

    initial begin
        logic [5:0] cards [4];
        cards = '{6'h05, 6'h1A, 6'h2C, 6'h3E};

        i_rst = 1'b1; i_req_draw = 3'b000; i_play = 1'b0; i_play_idx = '0; i_rd_idx = '0;
        i_deck_done = 1'b1; i_deck_drawn = 1'b0; i_deck_card = '0;
        #12;
        check("rst_count", 32'(o_count), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_draw", 32'(o_draw), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_play_card", 32'(o_play_card), 0);
        check("rst_insert", 32'(o_insert), 0);
        i_rst = 1'b0;
        step();

        // Four-card draw with deck ready
        i_req_draw = 3'b100;
        step();
        i_req_draw = 3'b000;
        check("d4_draw", 32'(o_draw), 4);
        check("d4_busy", 32'(o_busy), 1);
        for (int k = 0; k < 4; k++) begin
            i_deck_drawn = 1'b1;
            i_deck_card  = cards[k];
            step();
            check("d4_count", 32'(o_count), 32'(k + 1));
            check("d4_draw_hold", 32'(o_draw), (k < 3) ? 4 : 0);
        end
        i_deck_drawn = 1'b0;
        check("d4_busy_end", 32'(o_busy), 0);
        for (int k = 0; k < 4; k++) check_slot("d4_slot", k, 32'(cards[k]));
        check_slot("d4_slot_beyond", 4, 0);

        // Play slot 1 from {05,1A,2C,3E}
        step();
        i_play = 1'b1; i_play_idx = 5'd1;
        step();
        i_play = 1'b0;
        check("p1_insert", 32'(o_insert), 1);
        check("p1_card", 32'(o_play_card), 'h1A);
        step();
        check("p1_insert_off", 32'(o_insert), 0);
        check("p1_count", 32'(o_count), 3);
        check_slot("p1_slot0", 0, 'h05);
        check_slot("p1_slot1", 1, 'h2C);
        check_slot("p1_slot2", 2, 'h3E);
        check_slot("p1_slot3", 3, 0);

        // Play index equal to count is rejected
        step();
        i_play = 1'b1; i_play_idx = 5'd3;
        step();
        i_play = 1'b0;
        check("pbad_err", 32'(o_err), 1);
        check("pbad_busy", 32'(o_busy), 0);
        check("pbad_count", 32'(o_count), 3);
        step();
        check("pbad_err_pulse", 32'(o_err), 0);

        // Deck not ready: wait state, ignored requests and drawn strobes
        i_deck_done = 1'b0; i_req_draw = 3'b001;
        step();
        check("wd_busy", 32'(o_busy), 1);
        check("wd_draw", 32'(o_draw), 0);
        i_req_draw = 3'b011; i_play = 1'b1; i_play_idx = 5'd0;
        i_deck_drawn = 1'b1; i_deck_card = 6'h11;
        step();
        i_req_draw = 3'b000; i_play = 1'b0; i_deck_drawn = 1'b0;
        check("wd_no_err", 32'(o_err), 0);
        check("wd_count", 32'(o_count), 3);
        check("wd_still_busy", 32'(o_busy), 1);
        i_deck_done = 1'b1;
        step();
        check("wd_draw_on", 32'(o_draw), 1);
        i_deck_drawn = 1'b1; i_deck_card = 6'h33;
        step();
        i_deck_drawn = 1'b0;
        check("wd_count_inc", 32'(o_count), 4);
        check("wd_draw_off", 32'(o_draw), 0);
        check_slot("wd_slot3", 3, 'h33);

        // Draw and play together: draw wins, play dropped silently
        i_req_draw = 3'b001; i_play = 1'b1; i_play_idx = 5'd0;
        step();
        i_req_draw = 3'b000; i_play = 1'b0;
        check("pri_draw", 32'(o_draw), 1);
        check("pri_insert", 32'(o_insert), 0);
        check("pri_err", 32'(o_err), 0);
        i_deck_drawn = 1'b1; i_deck_card = 6'h07;
        step();
        i_deck_drawn = 1'b0;
        check("pri_count", 32'(o_count), 5);
        check_slot("pri_slot0", 0, 'h05);
        check_slot("pri_slot4", 4, 'h07);
        check("pri_play_card_held", 32'(o_play_card), 'h1A);

        // Non-one-hot draw code
        i_req_draw = 3'b011;
        step();
        i_req_draw = 3'b000;
        check("code_err", 32'(o_err), 1);
        check("code_draw", 32'(o_draw), 0);
        check("code_busy", 32'(o_busy), 0);

        // Fill to 15, then overflow checks
        draw_cards(3'b100, 4, 6'h20, 9);
        draw_cards(3'b100, 4, 6'h24, 13);
        draw_cards(3'b010, 2, 6'h28, 15);
        i_req_draw = 3'b010;
        step();
        i_req_draw = 3'b000;
        check("ovf_err", 32'(o_err), 1);
        check("ovf_draw", 32'(o_draw), 0);
        check("ovf_count", 32'(o_count), 15);
        step();
        check("ovf_err_pulse", 32'(o_err), 0);
        draw_cards(3'b001, 1, 6'h30, 16);
        check_slot("full_slot15", 15, 'h30);
        i_req_draw = 3'b001;
        step();
        i_req_draw = 3'b000;
        check("full_err", 32'(o_err), 1);
        check("full_count", 32'(o_count), 16);

        // Play top slot, then slot 0
        i_play = 1'b1; i_play_idx = 5'd15;
        step();
        i_play = 1'b0;
        check("ptop_card", 32'(o_play_card), 'h30);
        step();
        check("ptop_count", 32'(o_count), 15);
        i_play = 1'b1; i_play_idx = 5'd0;
        step();
        i_play = 1'b0;
        check("p0_card", 32'(o_play_card), 'h05);
        step();
        check("p0_count", 32'(o_count), 14);
        check_slot("p0_slot0", 0, 'h2C);

        // Reset after one of two cards collected
        i_req_draw = 3'b010;
        step();
        i_req_draw = 3'b000;
        i_deck_drawn = 1'b1; i_deck_card = 6'h15;
        step();
        i_deck_drawn = 1'b0;
        check("mid_count", 32'(o_count), 15);
        check("mid_draw", 32'(o_draw), 2);
        i_rst = 1'b1;
        #1;
        check("arst_draw", 32'(o_draw), 0);
        check("arst_count", 32'(o_count), 0);
        check("arst_busy", 32'(o_busy), 0);
        check("arst_play_card", 32'(o_play_card), 0);
        #1;
        i_rst = 1'b0;
        i_req_draw = 3'b001;
        step();
        i_req_draw = 3'b000;
        check("post_rst_draw", 32'(o_draw), 1);
        i_deck_drawn = 1'b1; i_deck_card = 6'h2A;
        step();
        i_deck_drawn = 1'b0;
        check("post_rst_count", 32'(o_count), 1);
        check_slot("post_rst_slot0", 0, 'h2A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/player_hand.md
PLAYER_HAND -- requirements
Module: player_hand

Interface
REQ-001 SHALL have parameter MAX_CARDS, default 16: maximum cards held, range 4..31.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port i_clk, input, 1: rising-edge clock.
REQ-004 SHALL have port i_rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port i_req_draw, input, 3: one-hot draw request; 001 = one card, 010 = two cards, 100 = four cards.
REQ-006 SHALL have port i_play, input, 1: play request, sampled with i_play_idx.
REQ-007 SHALL have port i_play_idx, input, 5: hand slot to play.
REQ-008 SHALL have port i_rd_idx, input, 5: hand slot to read for display.
REQ-009 SHALL have port i_deck_done, input, 1: deck idle flag.
REQ-010 SHALL have port i_deck_drawn, input, 1: deck card-valid strobe.
REQ-011 SHALL have port i_deck_card, input, 6: card from deck; [5:4] colour, [3:0] value.
REQ-012 SHALL have port o_draw, output, 3: draw request to deck, same one-hot code as i_req_draw.
REQ-013 SHALL have port o_insert, output, 1: one-cycle pulse; played card valid.
REQ-014 SHALL have port o_play_card, output, 6: played card.
REQ-015 SHALL have port o_rd_card, output, 6: combinational hand[i_rd_idx]; value is 0 when i_rd_idx >= count.
REQ-016 SHALL have port o_count, output, 5: number of cards held.
REQ-017 SHALL have port o_busy, output, 1: high in every state except S_IDLE.
REQ-018 SHALL have port o_err, output, 1: one-cycle pulse on a rejected request.

Function
REQ-019 SHALL implement states S_IDLE, S_WAIT_DECK, S_DRAW and S_PLAY.
REQ-020 SHALL store the hand as a MAX_CARDS x 6-bit array; slots 0..count-1 are valid and packed, with no holes.
REQ-021 SHALL accept a draw in S_IDLE only when i_req_draw is exactly one-hot and count+n <= MAX_CARDS (n = 1, 2 or 4).
- On acceptance: latch the code and set remaining = n.
- Go to S_DRAW if i_deck_done = 1, otherwise to S_WAIT_DECK.
REQ-022 SHALL, in S_WAIT_DECK, hold o_draw = 0 and move to S_DRAW on the first cycle i_deck_done = 1.
REQ-023 SHALL, in S_DRAW, drive o_draw = the latched code continuously, asserted from the cycle S_DRAW is entered.
REQ-024 SHALL, on each S_DRAW cycle with i_deck_drawn = 1:
- write i_deck_card to slot count;
- increment count;
- decrement remaining.
REQ-025 SHALL, when remaining reaches 0, drive o_draw = 0 on the next cycle and return to S_IDLE.
REQ-026 SHALL ignore i_deck_drawn in every state other than S_DRAW.
REQ-027 SHALL reject a non-one-hot, nonzero i_req_draw, or an overflowing draw, with one o_err pulse; count and state are unchanged.
REQ-028 SHALL accept a play in S_IDLE when i_play = 1 and i_play_idx < count.
- Register hand[idx] into o_play_card.
- Go to S_PLAY.
REQ-029 SHALL, in S_PLAY:
- assert o_insert for exactly one cycle;
- shift slots idx+1..count-1 down by one in that cycle;
- decrement count;
- return to S_IDLE.
REQ-030 SHALL reject i_play with i_play_idx >= count, including when count = 0, with one o_err pulse.
REQ-031 SHALL give the draw priority when i_req_draw is nonzero and i_play = 1 in the same S_IDLE cycle; the play is dropped with no o_err.
REQ-032 SHALL ignore i_req_draw and i_play while o_busy = 1, without asserting o_err.
REQ-033 SHALL hold o_play_card at its last played value until the next accepted play.
REQ-034 SHALL never let o_count exceed MAX_CARDS or go below 0.

Reset
REQ-035 SHALL, while i_rst = 1, asynchronously force:
- state = S_IDLE;
- o_count, remaining and all slots = 0;
- o_draw = 000, o_insert = 0, o_play_card = 0, o_busy = 0, o_err = 0.
REQ-036 SHALL, on reset asserted mid-draw or mid-play, drop o_draw/o_insert immediately and discard any partially collected cards.
REQ-037 SHALL accept a request on the first rising edge after i_rst deasserts.

Verification
REQ-038 SHALL pass this scenario: count = 0, i_deck_done = 1, i_req_draw = 100, four i_deck_drawn pulses with cards 0x05, 0x1A, 0x2C, 0x3E.
- o_draw = 100 until the 4th pulse.
- Then o_count = 4, o_rd_card(0..3) = 05, 1A, 2C, 3E, o_busy = 0.
REQ-039 SHALL pass this scenario: hand = {05, 1A, 2C, 3E}, i_play idx = 1.
- Next cycle: o_play_card = 1A, o_insert pulse.
- After: hand = {05, 2C, 3E}, o_count = 3.
REQ-040 SHALL pass this scenario: count = 15 with MAX_CARDS = 16, i_req_draw = 010.
- One o_err pulse, o_draw stays 000, o_count = 15.
REQ-041 SHALL pass this scenario: i_deck_done = 0, i_req_draw = 001.
- S_WAIT_DECK with o_draw = 000 and o_busy = 1.
- Raise i_deck_done: o_draw = 001; one drawn pulse with card 0x33 gives o_count +1.
REQ-042 SHALL pass this scenario: i_req_draw = 001 and i_play idx = 0 in the same cycle with count = 2.
- The draw is taken, no o_insert, no o_err.
REQ-043 SHALL pass this scenario: i_rst pulsed after 1 of 2 cards collected in a 010 draw.
- o_draw = 000 asynchronously, o_count = 0, state S_IDLE.
